sliding_window_gen: RTL and testbench

Parametrised streaming KxK window generator for the edge-detection pipeline. It replaces the fixed 3x3, 8-bit line buffer, and sits between the pixel source and the convolution/Sobel stage. Raster-order pixels enter through a valid/ready handshake, and the block emits one full WINxWIN neighbourhood per interior pixel. Each window carries centre coordinates and frame markers, and output backpressure is honoured.

---
 rtl/window_pkg.sv | 46 ++++
 rtl/sliding_window_gen_if.sv | 33 +++
 rtl/line_buffer_bank.sv | 37 +++
 rtl/sliding_window_gen.sv | 147 ++++++++++++++
 tb/tb_sliding_window_gen.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_pkg.sv
// Shared helpers for the sliding window generator: window geometry,
// element indexing, parameter legality and the per-window frame flags.
package window_pkg;

    localparam int unsigned WIN_MIN = 3;
    localparam int unsigned WIN_MAX = 7;

    // Frame markers carried alongside each emitted window.
    typedef struct packed {
        logic sof;
        logic eof;
    } win_flags_t;

    // Number of elements in a win x win neighbourhood.
    function automatic int unsigned win_elems(input int unsigned win);
        return win * win;
    endfunction

    // Distance from the window edge to its centre.
    function automatic int unsigned half_win(input int unsigned win);
        return (win - 1) / 2;
    endfunction

    // Flat element index; r=0 is the oldest row, c=0 the oldest column.
    function automatic int unsigned elem_idx(input int unsigned win,
                                             input int unsigned r,
                                             input int unsigned c);
        return r * win + c;
    endfunction

    // Legal configuration: odd window in range, image at least one window,
    // and image dimensions representable in the coordinate counters.
    function automatic bit params_ok(input int unsigned win,
                                     input int unsigned img_w,
                                     input int unsigned img_h,
                                     input int unsigned cnt_w);
        bit ok;
        ok = ((win % 2) == 1) && (win >= WIN_MIN) && (win <= WIN_MAX);
        ok = ok && (img_w >= win) && (img_h >= win);
        ok = ok && (cnt_w >= 1) && (cnt_w <= 32);
        ok = ok && (longint'(img_w) <= (longint'(1) << cnt_w));
        ok = ok && (longint'(img_h) <= (longint'(1) << cnt_w));
        return ok;
    endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel input stream and window output stream of the window generator.
interface sliding_window_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 3,
    parameter int unsigned CNT_W  = 16
);

    logic [DATA_W-1:0]         in_data;
    logic                      in_valid;
    logic                      in_sof;
    logic                      in_ready;

    logic [WIN*WIN*DATA_W-1:0] win_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          out_x;
    logic [CNT_W-1:0]          out_y;
    logic                      out_sof;
    logic                      out_eof;

    // Pixel source / window sink side.
    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, win_data, out_valid, out_x, out_y, out_sof, out_eof
    );

    // Window generator side.
    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, win_data, out_valid, out_x, out_y, out_sof, out_eof
    );

endinterface

// File: rtl/line_buffer_bank.sv
// ROWS previous lines of DEPTH pixels. Each write at column addr pushes din
// into row 0 and moves every row's entry at that column one row older.
module line_buffer_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ROWS   = 2,
    parameter int unsigned ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        din,
    output logic [ROWS*DATA_W-1:0]   rd_col
);

    // Storage is intentionally unreset; the consumer never exposes stale rows.
    logic [DATA_W-1:0] mem [ROWS][DEPTH];

    // Column read: row j of the selected column lands at slice j.
    always_comb begin
        rd_col = '0;
        for (int unsigned j = 0; j < ROWS; j++) begin
            rd_col[j*DATA_W +: DATA_W] = mem[j][addr];
        end
    end

    // Per-column shift write on each accepted pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[0][addr] <= din;
            for (int unsigned j = 1; j < ROWS; j++) begin
                mem[j][addr] <= mem[j-1][addr];
            end
        end
    end

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming WIN x WIN window generator: raster pixels in, one neighbourhood
// per interior pixel out, with centre coordinates and frame markers.
module sliding_window_gen
    import window_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned WIN    = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    sliding_window_gen_if.slave bus
);

    localparam int unsigned ELEMS    = win_elems(WIN);
    localparam int unsigned HALF     = half_win(WIN);
    localparam int unsigned LB_ROWS  = WIN - 1;
    localparam int unsigned WIN_BITS = ELEMS * DATA_W;
    localparam int unsigned COL_BITS = WIN * DATA_W;
    localparam int unsigned ADDR_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // Reject illegal geometry at elaboration.
    if (!params_ok(WIN, IMG_W, IMG_H, CNT_W)) begin : g_bad_params
        $error("sliding_window_gen: illegal WIN/IMG_W/IMG_H/CNT_W combination");
    end

    logic                     accept;
    logic [CNT_W-1:0]         x;
    logic [CNT_W-1:0]         y;
    logic [CNT_W-1:0]         x_eff;
    logic [CNT_W-1:0]         y_eff;
    logic [CNT_W-1:0]         x_next;
    logic [CNT_W-1:0]         y_next;
    logic                     interior;
    win_flags_t               flags_c;
    logic [ADDR_W-1:0]        lb_addr;
    logic [LB_ROWS*DATA_W-1:0] lb_col;
    logic [COL_BITS-1:0]      col_c;
    logic [WIN_BITS-1:0]      win_reg;
    logic [WIN_BITS-1:0]      win_next;

    // Single output stage: accept whenever the held window is empty or leaving.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Effective position of the incoming pixel; in_sof restarts at (0,0).
    always_comb begin
        x_eff = bus.in_sof ? '0 : x;
        y_eff = bus.in_sof ? '0 : y;
    end

    // Raster counter advance with line and frame wrap.
    always_comb begin
        x_next = x_eff + CNT_W'(1);
        y_next = y_eff;
        if (x_eff == CNT_W'(IMG_W - 1)) begin
            x_next = '0;
            if (y_eff == CNT_W'(IMG_H - 1)) begin
                y_next = '0;
            end else begin
                y_next = y_eff + CNT_W'(1);
            end
        end
    end

    // Position classification; rows before WIN-1 of a frame are suppressed,
    // which also hides line-buffer contents from before a restart or reset.
    always_comb begin
        interior    = (x_eff >= CNT_W'(WIN - 1)) && (y_eff >= CNT_W'(WIN - 1));
        flags_c.sof = (x_eff == CNT_W'(WIN - 1)) && (y_eff == CNT_W'(WIN - 1));
        flags_c.eof = (x_eff == CNT_W'(IMG_W - 1)) && (y_eff == CNT_W'(IMG_H - 1));
    end

    assign lb_addr = ADDR_W'(x_eff);

    line_buffer_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ROWS   (LB_ROWS),
        .ADDR_W (ADDR_W)
    ) u_line_buffer_bank (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (lb_addr),
        .din    (bus.in_data),
        .rd_col (lb_col)
    );

    // New column (oldest row first) and the window after shifting it in.
    always_comb begin
        col_c    = '0;
        win_next = '0;
        for (int unsigned r = 0; r < LB_ROWS; r++) begin
            col_c[r*DATA_W +: DATA_W] = lb_col[(LB_ROWS-1-r)*DATA_W +: DATA_W];
        end
        col_c[(WIN-1)*DATA_W +: DATA_W] = bus.in_data;
        for (int unsigned r = 0; r < WIN; r++) begin
            for (int unsigned c = 0; c < WIN; c++) begin
                if (c < WIN - 1) begin
                    win_next[elem_idx(WIN, r, c)*DATA_W +: DATA_W] =
                        win_reg[elem_idx(WIN, r, c + 1)*DATA_W +: DATA_W];
                end else begin
                    win_next[elem_idx(WIN, r, c)*DATA_W +: DATA_W] =
                        col_c[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Position counters and window shift register advance per accepted pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            win_reg <= '0;
        end else if (accept) begin
            x       <= x_next;
            y       <= y_next;
            win_reg <= win_next;
        end
    end

    // Output register: load on interior pixels, hold under backpressure,
    // otherwise drop valid once the held window has been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.win_data  <= '0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else if (accept && interior) begin
            bus.out_valid <= 1'b1;
            bus.win_data  <= win_next;
            bus.out_x     <= x_eff - CNT_W'(HALF);
            bus.out_y     <= y_eff - CNT_W'(HALF);
            bus.out_sof   <= flags_c.sof;
            bus.out_eof   <= flags_c.eof;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen: WIN=3 and WIN=5 instances on an
// 8x6 image, windows collected by a monitor and compared to a pixel model.
module tb_sliding_window_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    typedef struct {
        logic [255:0] win;
        int           x;
        int           y;
        logic         sof;
        logic         eof;
    } rec_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       out_ready;
    logic       sel5;

    int n_checks;
    int n_errors;

    rec_t got_q[$];
    rec_t exp_q[$];

    sliding_window_gen_if #(.DATA_W(8), .WIN(3), .CNT_W(16)) bus3 ();
    sliding_window_gen_if #(.DATA_W(8), .WIN(5), .CNT_W(16)) bus5 ();

    assign bus3.in_data   = in_data;
    assign bus3.in_valid  = in_valid && !sel5;
    assign bus3.in_sof    = in_sof;
    assign bus3.out_ready = out_ready;
    assign bus5.in_data   = in_data;
    assign bus5.in_valid  = in_valid && sel5;
    assign bus5.in_sof    = in_sof;
    assign bus5.out_ready = out_ready;

    sliding_window_gen #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(3), .CNT_W(16)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    sliding_window_gen #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(5), .CNT_W(16)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    logic         in_ready_m;
    logic         out_valid_m;
    logic         sof_m;
    logic         eof_m;
    logic [15:0]  x_m;
    logic [15:0]  y_m;
    logic [255:0] win_m;

    always_comb begin
        if (sel5) begin
            in_ready_m  = bus5.in_ready;
            out_valid_m = bus5.out_valid;
            sof_m       = bus5.out_sof;
            eof_m       = bus5.out_eof;
            x_m         = bus5.out_x;
            y_m         = bus5.out_y;
            win_m       = 256'(bus5.win_data);
        end else begin
            in_ready_m  = bus3.in_ready;
            out_valid_m = bus3.out_valid;
            sof_m       = bus3.out_sof;
            eof_m       = bus3.out_eof;
            x_m         = bus3.out_x;
            y_m         = bus3.out_y;
            win_m       = 256'(bus3.win_data);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every window handshake of the selected instance.
    always @(negedge clk) begin
        if (!reset && out_valid_m && out_ready) begin
            rec_t r;
            r.win = win_m;
            r.x   = int'(x_m);
            r.y   = int'(y_m);
            r.sof = sof_m;
            r.eof = eof_m;
            got_q.push_back(r);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_win(input int win, input int base, input int cx, input int cy);
        logic [255:0] v;
        int h;
        v = '0;
        h = (win - 1) / 2;
        for (int r = 0; r < win; r++) begin
            for (int c = 0; c < win; c++) begin
                v[(r*win+c)*8 +: 8] = 8'(base + (cy - h + r) * 16 + (cx - h + c));
            end
        end
        return v;
    endfunction

    // Append the first 'limit' windows of a frame whose pixel is base+y*16+x.
    task automatic append_exp(input int base, input int win, input int limit);
        int h;
        int n;
        rec_t r;
        h = (win - 1) / 2;
        n = 0;
        for (int cy = h; cy <= IMG_H - 1 - h; cy++) begin
            for (int cx = h; cx <= IMG_W - 1 - h; cx++) begin
                if (n < limit) begin
                    r.win = exp_win(win, base, cx, cy);
                    r.x   = cx;
                    r.y   = cy;
                    r.sof = (cx == h) && (cy == h);
                    r.eof = (cx == IMG_W - 1 - h) && (cy == IMG_H - 1 - h);
                    exp_q.push_back(r);
                end
                n++;
            end
        end
    endtask

    task automatic compare_seq(input string tag);
        int n;
        check($sformatf("%s.count", tag), 256'(got_q.size()), 256'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].win", tag, i), got_q[i].win, exp_q[i].win);
            check($sformatf("%s[%0d].xy", tag, i), {224'(0), 16'(got_q[i].x), 16'(got_q[i].y)},
                  {224'(0), 16'(exp_q[i].x), 16'(exp_q[i].y)});
            check($sformatf("%s[%0d].sof_eof", tag, i), {254'(0), got_q[i].sof, got_q[i].eof},
                  {254'(0), exp_q[i].sof, exp_q[i].eof});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle_cycle(input bit rnd);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (rnd) out_ready = 1'($urandom % 2);
        @(posedge clk);
        #1;
    endtask

    // Present one pixel until accepted; returns 1 time unit after the accepting edge.
    task automatic drive_pixel(input logic [7:0] d, input logic sof, input bit rnd);
        bit acc;
        acc      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = sof;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (rnd) out_ready = 1'($urandom % 2);
            @(negedge clk);
            acc = in_ready_m;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 256'(0), 256'(1));
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drive_frame(input int base, input int win, input int npix, input int stall_idx,
                               input int lat_idx, input bit rnd, input bit drain, input bit use_sof);
        int h;
        int px;
        int py;
        h = (win - 1) / 2;
        for (int i = 0; i < npix; i++) begin
            px = i % IMG_W;
            py = i / IMG_W;
            if (rnd) begin
                for (int g = 0; g < 4 && ($urandom % 2) == 1; g++) idle_cycle(1'b1);
            end
            if (i == stall_idx) begin
                in_data   = 8'(base + py * 16 + px);
                in_valid  = 1'b1;
                in_sof    = 1'b0;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall.in_ready", 256'(in_ready_m), 256'(0));
                    check("stall.win", win_m,
                          exp_win(win, base, (i - 1) % IMG_W - h, (i - 1) / IMG_W - h));
                    check("stall.xy", {224'(0), x_m, y_m},
                          {224'(0), 16'((i - 1) % IMG_W - h), 16'((i - 1) / IMG_W - h)});
                    @(posedge clk);
                    #1;
                end
            end
            if (!rnd) out_ready = 1'b1;
            drive_pixel(8'(base + py * 16 + px), use_sof && (i == 0), rnd);
            if (i == lat_idx - 1) check("latency.pre", 256'(out_valid_m), 256'(0));
            if (i == lat_idx)     check("latency.valid", 256'(out_valid_m), 256'(1));
        end
        if (drain) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.out_valid", tag), 256'(out_valid_m), 256'(0));
        check($sformatf("%s.win", tag), win_m, 256'(0));
        check($sformatf("%s.xy", tag), {224'(0), x_m, y_m}, 256'(0));
        check($sformatf("%s.sof_eof", tag), {254'(0), sof_m, eof_m}, 256'(0));
        check($sformatf("%s.in_ready", tag), 256'(in_ready_m), 256'(1));
    endtask

    // Abort a frame partway through with reset, then run a clean frame without in_sof.
    task automatic reset_then_frame(input int win, input int lat_idx, input string tag);
        drive_frame(0, win, 30, -1, -1, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        append_exp(0, win, 1000);
        drive_frame(0, win, IMG_W * IMG_H, -1, lat_idx, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        sel5      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Continuous stream, downstream always ready.
        append_exp(0, 3, 1000);
        drive_frame(0, 3, IMG_W * IMG_H, -1, 18, 1'b0, 1'b1, 1'b1);
        if (got_q.size() == 24) begin
            check("s1.first_e0_e8", {240'(0), got_q[0].win[7:0], got_q[0].win[71:64]}, 256'(16'h0022));
            check("s1.last_e8", 256'(got_q[23].win[71:64]), 256'(8'h57));
        end
        compare_seq("s1");

        // Five-cycle backpressure on the window at centre (3,2).
        append_exp(0, 3, 1000);
        drive_frame(0, 3, IMG_W * IMG_H, 29, -1, 1'b0, 1'b1, 1'b1);
        compare_seq("s2");

        // Random input gaps and random downstream ready.
        append_exp(0, 3, 1000);
        drive_frame(0, 3, IMG_W * IMG_H, -1, -1, 1'b1, 1'b1, 1'b1);
        compare_seq("s3");

        // Two frames back to back with distinct pixel values.
        append_exp(0, 3, 1000);
        append_exp(8'h80, 3, 1000);
        drive_frame(0, 3, IMG_W * IMG_H, -1, -1, 1'b0, 1'b0, 1'b1);
        drive_frame(8'h80, 3, IMG_W * IMG_H, -1, -1, 1'b0, 1'b1, 1'b1);
        compare_seq("s4");

        // in_sof at pixel (4,3): eight old-frame windows, then a fresh frame.
        append_exp(0, 3, 8);
        append_exp(8'h80, 3, 1000);
        drive_frame(0, 3, 28, -1, -1, 1'b0, 1'b0, 1'b1);
        drive_frame(8'h80, 3, IMG_W * IMG_H, -1, -1, 1'b0, 1'b1, 1'b1);
        compare_seq("s5");

        // Mid-frame reset, WIN=3.
        reset_then_frame(3, 18, "s6.reset");
        compare_seq("s6");

        // Mid-frame reset, WIN=5.
        sel5 = 1'b1;
        reset_then_frame(5, 36, "s7.reset");
        if (got_q.size() == 8) begin
            check("s7.first_e0", 256'(got_q[0].win[7:0]), 256'(8'h00));
            check("s7.first_e24", 256'(got_q[0].win[199:192]), 256'(8'h44));
        end
        compare_seq("s7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
